// File: rtl/instr_controller_pkg.sv
// Shared encodings for the instruction-sequencing controller: states, opcode
// fields, instruction classes and the mux/ALU codes it drives.
package instr_controller_pkg;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StFault  = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ClsAlu,
      ClsCmp,
      ClsLoad,
      ClsStor,
      ClsJal,
      ClsJcond,
      ClsBcond,
      ClsIllegal
   } cls_e;

   // Opcodes, ir[15:12]
   localparam logic [3:0] OpRtype  = 4'b0000;
   localparam logic [3:0] OpAndi   = 4'b0001;
   localparam logic [3:0] OpOri    = 4'b0010;
   localparam logic [3:0] OpXori   = 4'b0011;
   localparam logic [3:0] OpMemJmp = 4'b0100;
   localparam logic [3:0] OpAddi   = 4'b0101;
   localparam logic [3:0] OpAddui  = 4'b0110;
   localparam logic [3:0] OpSubi   = 4'b1001;
   localparam logic [3:0] OpCmpi   = 4'b1011;
   localparam logic [3:0] OpBcond  = 4'b1100;
   localparam logic [3:0] OpMovi   = 4'b1101;
   localparam logic [3:0] OpMuli   = 4'b1110;

   // Extension field, ir[7:4]
   localparam logic [3:0] ExtLoad  = 4'b0000;
   localparam logic [3:0] ExtStor  = 4'b0100;
   localparam logic [3:0] ExtJal   = 4'b1000;
   localparam logic [3:0] ExtCmp   = 4'b1011;
   localparam logic [3:0] ExtJcond = 4'b1100;

   localparam logic [1:0] PcSrcInc = 2'b00;
   localparam logic [1:0] PcSrcRel = 2'b01;
   localparam logic [1:0] PcSrcReg = 2'b10;

   localparam logic [1:0] WbAlu = 2'b00;
   localparam logic [1:0] WbMem = 2'b01;
   localparam logic [1:0] WbPc  = 2'b10;

   // ALU codes share the numbering of the immediate opcodes and R-type extensions
   localparam logic [3:0] AluNop  = 4'b0000;
   localparam logic [3:0] AluAnd  = 4'b0001;
   localparam logic [3:0] AluOr   = 4'b0010;
   localparam logic [3:0] AluXor  = 4'b0011;
   localparam logic [3:0] AluAdd  = 4'b0101;
   localparam logic [3:0] AluAddu = 4'b0110;
   localparam logic [3:0] AluSub  = 4'b1001;
   localparam logic [3:0] AluCmp  = 4'b1011;
   localparam logic [3:0] AluMov  = 4'b1101;
   localparam logic [3:0] AluMul  = 4'b1110;

   function automatic logic is_imm_op(input logic [3:0] op);
      return op inside {OpAndi, OpOri, OpXori, OpAddi, OpAddui, OpSubi, OpCmpi, OpMovi, OpMuli};
   endfunction

   function automatic logic is_signed_imm(input logic [3:0] op);
      return op inside {OpAddi, OpAddui, OpSubi, OpCmpi, OpMuli};
   endfunction

endpackage

// File: rtl/instr_controller_decoder.sv
// Combinational instruction decoder: classifies the latched IR and produces
// the ALU code and immediate-extender controls.
module instr_decoder
   import instr_controller_pkg::*;
(
   input  logic [15:0] ir_i,
   output cls_e        cls_o,
   output logic [3:0]  alu_op_o,
   output logic        imm_sel_o,
   output logic        se_signed_o,
   output logic        illegal_o
);

   logic [3:0] op;
   logic [3:0] ext;
   logic       unused_ir_bits;

   assign op  = ir_i[15:12];
   assign ext = ir_i[7:4];
   // Condition and register fields are consumed by the datapath, not here
   assign unused_ir_bits = ^{ir_i[11:8], ir_i[3:0]};

   always_comb begin
      cls_o       = ClsIllegal;
      alu_op_o    = AluNop;
      imm_sel_o   = 1'b0;
      se_signed_o = 1'b0;
      if (op == OpRtype) begin
         cls_o    = (ext == ExtCmp) ? ClsCmp : ClsAlu;
         alu_op_o = ext;
      end else if (is_imm_op(op)) begin
         cls_o       = (op == OpCmpi) ? ClsCmp : ClsAlu;
         alu_op_o    = op;
         imm_sel_o   = 1'b1;
         se_signed_o = is_signed_imm(op);
      end else if (op == OpMemJmp) begin
         case (ext)
            ExtLoad:  cls_o = ClsLoad;
            ExtStor:  cls_o = ClsStor;
            ExtJal:   cls_o = ClsJal;
            ExtJcond: cls_o = ClsJcond;
            default:  cls_o = ClsIllegal;
         endcase
      end else if (op == OpBcond) begin
         cls_o       = ClsBcond;
         se_signed_o = 1'b1;
      end
   end

   assign illegal_o = (cls_o == ClsIllegal);

endmodule

// File: rtl/instr_controller.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback FSM
// with a memory-wait watchdog and a sticky fault state left only by reset.
module instr_controller
   import instr_controller_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] instr,
   input  logic        mem_ack,
   input  logic        cond_true,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        ir_load,
   output logic        pc_en,
   output logic [1:0]  pc_src,
   output logic        imm_sel,
   output logic        se_signed,
   output logic [3:0]  alu_op,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        fault,
   output logic        illegal,
   output logic [2:0]  state_o
);

   // WIDTH only sizes the datapath this block steers
   localparam int unsigned unused_width = WIDTH;
   localparam logic [7:0]  WaitLast     = 8'(TIMEOUT - 1);

   state_e      state_q;
   logic [15:0] ir_q;
   logic [7:0]  wait_q;
   logic        fault_q;
   logic        illegal_q;

   cls_e        cls;
   logic        dec_illegal;

   instr_decoder u_decoder (
      .ir_i        (ir_q),
      .cls_o       (cls),
      .alu_op_o    (alu_op),
      .imm_sel_o   (imm_sel),
      .se_signed_o (se_signed),
      .illegal_o   (dec_illegal)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StFetch;
         ir_q      <= '0;
         wait_q    <= '0;
         fault_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            StFetch: begin
               if (mem_ack) begin
                  ir_q    <= instr;
                  state_q <= StDecode;
               end else if (wait_q == WaitLast) begin
                  state_q <= StFault;
                  fault_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            StDecode: begin
               if (dec_illegal) begin
                  state_q   <= StFault;
                  fault_q   <= 1'b1;
                  illegal_q <= 1'b1;
               end else begin
                  state_q <= StExec;
               end
            end
            StExec: begin
               case (cls)
                  ClsAlu, ClsJal: state_q <= StWb;
                  ClsCmp, ClsBcond, ClsJcond: begin
                     state_q <= StFetch;
                     wait_q  <= '0;
                  end
                  ClsLoad, ClsStor: begin
                     state_q <= StMem;
                     wait_q  <= '0;
                  end
                  default: begin
                     state_q   <= StFault;
                     fault_q   <= 1'b1;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            StMem: begin
               if (mem_ack) begin
                  if (cls == ClsLoad) begin
                     state_q <= StWb;
                  end else begin
                     state_q <= StFetch;
                     wait_q  <= '0;
                  end
               end else if (wait_q == WaitLast) begin
                  state_q <= StFault;
                  fault_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            StWb: begin
               state_q <= StFetch;
               wait_q  <= '0;
            end
            StFault: state_q <= StFault;
            default: begin
               state_q <= StFault;
               fault_q <= 1'b1;
            end
         endcase
      end
   end

   // Strobes are qualified by reset_n so an in-flight access drops at once
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_load  = 1'b0;
      pc_en    = 1'b0;
      pc_src   = PcSrcInc;
      rf_we    = 1'b0;
      if (reset_n) begin
         case (state_q)
            StFetch: begin
               mem_req = 1'b1;
               ir_load = mem_ack;
               pc_en   = mem_ack;
            end
            StExec: begin
               case (cls)
                  ClsBcond: begin
                     pc_en  = cond_true;
                     pc_src = PcSrcRel;
                  end
                  ClsJcond: begin
                     pc_en  = cond_true;
                     pc_src = PcSrcReg;
                  end
                  ClsJal: begin
                     pc_en  = 1'b1;
                     pc_src = PcSrcReg;
                  end
                  default: ;
               endcase
            end
            StMem: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = (cls == ClsStor);
            end
            StWb:    rf_we = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (cls)
         ClsLoad: wb_sel = WbMem;
         ClsJal:  wb_sel = WbPc;
         default: wb_sel = WbAlu;
      endcase
   end

   assign fault   = fault_q;
   assign illegal = illegal_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_instr_controller.sv
// Scoreboard bench: stimulus pushes expected per-cycle control words derived
// from the instruction-class rules; a negedge monitor pops and compares.
module tb_instr_controller;

   localparam int TO = 15;
   localparam int CAlu = 0, CCmp = 1, CLoad = 2, CStor = 3, CJal = 4, CJcond = 5, CBcond = 6,
                  CIll = 7;

   logic        clk, reset_n, mem_ack, cond_true;
   logic [15:0] instr;
   logic        mem_req, mem_we, addr_sel, ir_load, pc_en, imm_sel, se_signed, rf_we;
   logic        fault, illegal;
   logic [1:0]  pc_src, wb_sel;
   logic [3:0]  alu_op;
   logic [2:0]  state_o;

   typedef struct {
      int st;
      bit req, we, asel, irl, pce;
      int src;
      bit rfwe;
      int wb;
      bit flt, ill, chk_dec, imm, se, chk_alu;
      int alu;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_on = 0;

   instr_controller #(.WIDTH(16), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .instr     (instr),
      .mem_ack   (mem_ack),
      .cond_true (cond_true),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .addr_sel  (addr_sel),
      .ir_load   (ir_load),
      .pc_en     (pc_en),
      .pc_src    (pc_src),
      .imm_sel   (imm_sel),
      .se_signed (se_signed),
      .alu_op    (alu_op),
      .rf_we     (rf_we),
      .wb_sel    (wb_sel),
      .fault     (fault),
      .illegal   (illegal),
      .state_o   (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit [15:0] rw();
      return 16'($urandom);
   endfunction

   function automatic exp_t mk(input int st);
      exp_t e;
      e = '{default: 0};
      e.st = st;
      return e;
   endfunction

   function automatic int tb_class(input bit [15:0] w);
      bit [3:0] op;
      bit [3:0] ext;
      op  = w[15:12];
      ext = w[7:4];
      if (op == 4'h0) return (ext == 4'hB) ? CCmp : CAlu;
      if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD, 4'hE})
         return (op == 4'hB) ? CCmp : CAlu;
      if (op == 4'h4) begin
         case (ext)
            4'h0:    return CLoad;
            4'h4:    return CStor;
            4'h8:    return CJal;
            4'hC:    return CJcond;
            default: return CIll;
         endcase
      end
      if (op == 4'hC) return CBcond;
      return CIll;
   endfunction

   always @(negedge clk) begin
      if (mon_on && reset_n) begin
         if (exp_q.size() == 0) begin
            chk("scoreboard_depth", exp_q.size(), 1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("state", int'(state_o), mon_e.st);
            chk("mem_req", int'(mem_req), int'(mon_e.req));
            if (mon_e.req) begin
               chk("mem_we", int'(mem_we), int'(mon_e.we));
               chk("addr_sel", int'(addr_sel), int'(mon_e.asel));
            end
            chk("ir_load", int'(ir_load), int'(mon_e.irl));
            chk("pc_en", int'(pc_en), int'(mon_e.pce));
            if (mon_e.pce) chk("pc_src", int'(pc_src), mon_e.src);
            chk("rf_we", int'(rf_we), int'(mon_e.rfwe));
            if (mon_e.rfwe) chk("wb_sel", int'(wb_sel), mon_e.wb);
            chk("fault", int'(fault), int'(mon_e.flt));
            chk("illegal", int'(illegal), int'(mon_e.ill));
            if (mon_e.chk_dec) begin
               chk("imm_sel", int'(imm_sel), int'(mon_e.imm));
               chk("se_signed", int'(se_signed), int'(mon_e.se));
            end
            if (mon_e.chk_alu) chk("alu_op", int'(alu_op), mon_e.alu);
         end
      end
   end

   task automatic cycle(input bit ack, input bit [15:0] w, input bit c, input exp_t e);
      mem_ack   = ack;
      instr     = w;
      cond_true = c;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      mem_ack = rb();
      #1;
      chk("rst_state", int'(state_o), 0);
      chk("rst_mem_req", int'(mem_req), 0);
      chk("rst_rf_we", int'(rf_we), 0);
      chk("rst_ir_load", int'(ir_load), 0);
      chk("rst_pc_en", int'(pc_en), 0);
      chk("rst_fault", int'(fault), 0);
      chk("rst_illegal", int'(illegal), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic fault_tail(input bit ill);
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e = mk(5);
         e.flt = 1'b1;
         e.ill = ill;
         cycle(rb(), rw(), rb(), e);
      end
      apply_reset();
   endtask

   // Non-ack cycles of a FETCH (st=0) or MEM (st=3) access; ok=0 once it times out
   task automatic wait_phase(input int st, input int n, input bit we, output bit ok);
      exp_t e;
      for (int i = 0; i < n && i < TO; i++) begin
         e = mk(st);
         e.req  = 1'b1;
         e.asel = (st == 3);
         e.we   = we;
         cycle(1'b0, rw(), rb(), e);
      end
      ok = (n < TO);
      if (!ok) fault_tail(1'b0);
   endtask

   task automatic run_instr(input bit [15:0] w, input int fw, input int mw, input bit c,
                            input bit rst_mem);
      exp_t     e;
      int       cls;
      bit       ok;
      bit [3:0] op;
      cls = tb_class(w);
      op  = w[15:12];
      wait_phase(0, fw, 1'b0, ok);
      if (!ok) return;
      e = mk(0);
      e.req = 1'b1;
      e.irl = 1'b1;
      e.pce = 1'b1;
      e.src = 0;
      cycle(1'b1, w, rb(), e);
      cycle(rb(), rw(), rb(), mk(1));
      if (cls == CIll) begin
         fault_tail(1'b1);
         return;
      end
      e = mk(2);
      e.chk_dec = 1'b1;
      e.imm = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD, 4'hE};
      e.se  = op inside {4'h5, 4'h6, 4'h9, 4'hB, 4'hE, 4'hC};
      if (cls == CAlu || cls == CCmp) begin
         e.chk_alu = 1'b1;
         e.alu = (op == 4'h0) ? int'(w[7:4]) : int'(op);
      end
      case (cls)
         CBcond: begin e.pce = c;    e.src = 1; end
         CJcond: begin e.pce = c;    e.src = 2; end
         CJal:   begin e.pce = 1'b1; e.src = 2; end
         default: ;
      endcase
      cycle(rb(), rw(), c, e);
      if (cls == CLoad || cls == CStor) begin
         if (rst_mem) begin
            e = mk(3);
            e.req  = 1'b1;
            e.asel = 1'b1;
            e.we   = (cls == CStor);
            cycle(1'b0, rw(), rb(), e);
            chk("mem_req_before_reset", int'(mem_req), 1);
            apply_reset();
            return;
         end
         wait_phase(3, mw, cls == CStor, ok);
         if (!ok) return;
         e = mk(3);
         e.req  = 1'b1;
         e.asel = 1'b1;
         e.we   = (cls == CStor);
         cycle(1'b1, rw(), rb(), e);
      end
      if (cls == CAlu || cls == CJal || cls == CLoad) begin
         e = mk(4);
         e.rfwe = 1'b1;
         e.wb = (cls == CLoad) ? 1 : (cls == CJal) ? 2 : 0;
         cycle(rb(), rw(), rb(), e);
      end
   endtask

   initial begin
      bit [15:0] w;
      int        fw, mw;
      reset_n   = 1'b1;
      mem_ack   = 1'b0;
      cond_true = 1'b0;
      instr     = '0;
      @(posedge clk);
      #1;
      apply_reset();
      mon_on = 1'b1;

      run_instr(16'h5180, 0, 0, 1'b0, 1'b0);   // ADDI
      run_instr(16'h2180, 0, 0, 1'b0, 1'b0);   // ORI
      run_instr(16'h4102, 0, 3, 1'b0, 1'b0);   // LOAD, 3 wait cycles
      run_instr(16'h4142, 0, 0, 1'b0, 1'b0);   // STOR
      run_instr(16'hC1FE, 0, 0, 1'b1, 1'b0);   // Bcond taken
      run_instr(16'hC1FE, 0, 0, 1'b0, 1'b0);   // Bcond not taken
      run_instr(16'h41C2, 1, 0, 1'b1, 1'b0);   // Jcond taken
      run_instr(16'h41C2, 0, 0, 1'b0, 1'b0);   // Jcond not taken
      run_instr(16'h4182, 2, 0, 1'b0, 1'b0);   // JAL
      run_instr(16'h01B2, 0, 0, 1'b0, 1'b0);   // CMP
      run_instr(16'hB105, 0, 0, 1'b0, 1'b0);   // CMPI
      run_instr(16'h5180, TO, 0, 1'b0, 1'b0);  // fetch timeout
      run_instr(16'h5180, TO - 1, 0, 1'b0, 1'b0);
      run_instr(16'h4102, 0, TO, 1'b0, 1'b0);  // memory timeout
      run_instr(16'h4102, 0, TO - 1, 1'b0, 1'b0);
      run_instr(16'h7123, 0, 0, 1'b0, 1'b0);   // undefined opcode
      run_instr(16'h4142, 0, 5, 1'b0, 1'b1);   // reset during STOR memory phase
      run_instr(16'h5180, TO - 1, 0, 1'b0, 1'b0);

      for (int n = 0; n < 80; n++) begin
         bit [3:0] op;
         bit [3:0] ext;
         op  = 4'($urandom);
         ext = (op == 4'h4 && $urandom_range(0, 4) != 0) ? 4'($urandom_range(0, 3) * 4)
                                                          : 4'($urandom);
         w  = {op, 4'($urandom), ext, 4'($urandom)};
         fw = ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 19) == 0) ? TO - int'($urandom_range(0, 1))
                                           : int'($urandom_range(0, 3));
         run_instr(w, fw, mw, rb(), 1'b0);
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      mon_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
